// File: rtl/maxpool_tile_sequencer_if.sv
// Tile-handshake, pooled-result and output-buffer write signals of the sequencer.
`timescale 1ns/1ps
interface maxpool_tile_sequencer_if #(
    parameter int unsigned N_BITS    = 10,
    parameter int unsigned ADDR_BITS = 16
);
    logic                 tile_valid;
    logic                 tile_ready;
    logic [N_BITS-1:0]    pos_row;
    logic [N_BITS-1:0]    pos_col;
    logic                 pool_valid;
    logic [N_BITS-1:0]    pool_row;
    logic [N_BITS-1:0]    pool_col;
    logic [7:0]           pool_data;   // int8, two's complement
    logic                 wr_valid;
    logic [ADDR_BITS-1:0] wr_addr;
    logic [7:0]           wr_data;     // int8, two's complement

    // Sequencer side
    modport master (
        output tile_valid, pos_row, pos_col, wr_valid, wr_addr, wr_data,
        input  tile_ready, pool_valid, pool_row, pool_col, pool_data
    );

    // Producer / pooling unit / output buffer side
    modport slave (
        input  tile_valid, pos_row, pos_col, wr_valid, wr_addr, wr_data,
        output tile_ready, pool_valid, pool_row, pool_col, pool_data
    );
endinterface

// File: rtl/maxpool_tile_sequencer.sv
// Walks SA_N x SA_N tiles over a feature map, hands tile origins to the producer,
// counts pooled results per tile and turns each pooled coordinate into a write address.
`timescale 1ns/1ps
module maxpool_tile_sequencer #(
    parameter int unsigned SA_N      = 4,
    parameter int unsigned MAX_N     = 512,
    parameter int unsigned N_BITS    = $clog2(MAX_N + 1),
    parameter int unsigned FILTER_H  = 2,
    parameter int unsigned FILTER_W  = 2,
    parameter int unsigned ADDR_BITS = $clog2((MAX_N / FILTER_H) * (MAX_N / FILTER_W))
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [N_BITS-1:0] mat_rows,
    input  logic [N_BITS-1:0] mat_cols,
    output logic              busy,
    output logic              done,
    output logic              cfg_err,
    output logic              pool_err,
    maxpool_tile_sequencer_if.master bus
);

    localparam int unsigned LOG_FH    = $clog2(FILTER_H);
    localparam int unsigned LOG_FW    = $clog2(FILTER_W);
    localparam int unsigned SUM_BITS  = N_BITS + 1;
    localparam int unsigned TDIM_BITS = $clog2(SA_N + 1);
    localparam int unsigned EXP_BITS  = 2 * TDIM_BITS;
    localparam int unsigned CNT_BITS  = N_BITS;
    localparam int unsigned FULL_BITS = 2 * N_BITS + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_COLLECT,
        S_DONE
    } state_e;

    state_e               state_q, state_d;
    logic [N_BITS-1:0]    rows_q, rows_d;
    logic [N_BITS-1:0]    cols_q, cols_d;
    logic [N_BITS-1:0]    pos_row_q, pos_row_d;
    logic [N_BITS-1:0]    pos_col_q, pos_col_d;
    logic [CNT_BITS-1:0]  cnt_q, cnt_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 cfg_err_q, cfg_err_d;
    logic                 pool_err_q, pool_err_d;
    logic                 tile_valid_q, tile_valid_d;
    logic                 wr_valid_q, wr_valid_d;
    logic [ADDR_BITS-1:0] wr_addr_q, wr_addr_d;
    logic [7:0]           wr_data_q, wr_data_d;

    logic [N_BITS-1:0]    rem_rows, rem_cols;
    logic [TDIM_BITS-1:0] tile_h, tile_w;
    logic [EXP_BITS-1:0]  exp_cnt;
    logic [CNT_BITS-1:0]  cnt_inc;
    logic [SUM_BITS-1:0]  next_row, next_col;
    logic                 col_wrap, last_tile;
    logic                 cfg_ok, in_tile, stray;
    logic [FULL_BITS-1:0] lin_addr;

    // Tile geometry, drain bookkeeping, config check and address arithmetic
    always_comb begin
        rem_rows  = rows_q - pos_row_q;
        rem_cols  = cols_q - pos_col_q;
        tile_h    = (rem_rows < N_BITS'(SA_N)) ? TDIM_BITS'(rem_rows) : TDIM_BITS'(SA_N);
        tile_w    = (rem_cols < N_BITS'(SA_N)) ? TDIM_BITS'(rem_cols) : TDIM_BITS'(SA_N);
        exp_cnt   = EXP_BITS'(tile_h >> LOG_FH) * EXP_BITS'(tile_w >> LOG_FW);
        cnt_inc   = cnt_q + CNT_BITS'(bus.pool_valid);

        next_row  = SUM_BITS'(pos_row_q) + SUM_BITS'(SA_N);
        next_col  = SUM_BITS'(pos_col_q) + SUM_BITS'(SA_N);
        col_wrap  = next_col >= SUM_BITS'(cols_q);
        last_tile = col_wrap && (next_row >= SUM_BITS'(rows_q));

        cfg_ok    = (mat_rows != '0) && (mat_cols != '0)
                 && (mat_rows <= N_BITS'(MAX_N)) && (mat_cols <= N_BITS'(MAX_N))
                 && ((mat_rows & N_BITS'(FILTER_H - 1)) == '0)
                 && ((mat_cols & N_BITS'(FILTER_W - 1)) == '0);

        in_tile   = (bus.pool_row >= pos_row_q) && (SUM_BITS'(bus.pool_row) < next_row)
                 && (bus.pool_col >= pos_col_q) && (SUM_BITS'(bus.pool_col) < next_col);
        stray     = bus.pool_valid
                 && ((state_q == S_IDLE) || (state_q == S_DONE) || !in_tile);

        // Single multiplier: pooled row times pooled map width
        lin_addr  = FULL_BITS'(bus.pool_row >> LOG_FH) * FULL_BITS'(cols_q >> LOG_FW)
                  + FULL_BITS'(bus.pool_col >> LOG_FW);
    end

    // Next-state and output decode
    always_comb begin
        state_d    = state_q;
        rows_d     = rows_q;
        cols_d     = cols_q;
        pos_row_d  = pos_row_q;
        pos_col_d  = pos_col_q;
        cnt_d      = cnt_q;
        cfg_err_d  = cfg_err_q;
        pool_err_d = pool_err_q | stray;
        wr_valid_d = bus.pool_valid;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;

        if (bus.pool_valid) begin
            wr_addr_d = ADDR_BITS'(lin_addr);
            wr_data_d = bus.pool_data;
        end

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (cfg_ok) begin
                        rows_d     = mat_rows;
                        cols_d     = mat_cols;
                        pos_row_d  = '0;
                        pos_col_d  = '0;
                        cnt_d      = '0;
                        cfg_err_d  = 1'b0;
                        pool_err_d = stray;
                        state_d    = S_ISSUE;
                    end else begin
                        cfg_err_d  = 1'b1;
                    end
                end
            end
            S_ISSUE: begin
                cnt_d = cnt_inc;
                if (bus.tile_ready) begin
                    state_d = S_COLLECT;
                end
            end
            S_COLLECT: begin
                cnt_d = cnt_inc;
                if (cnt_inc >= CNT_BITS'(exp_cnt)) begin
                    cnt_d = '0;
                    if (last_tile) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_ISSUE;
                        if (col_wrap) begin
                            pos_col_d = '0;
                            pos_row_d = N_BITS'(next_row);
                        end else begin
                            pos_col_d = N_BITS'(next_col);
                        end
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d       = (state_d != S_IDLE);
        done_d       = (state_d == S_DONE);
        tile_valid_d = (state_d == S_ISSUE);
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            rows_q       <= '0;
            cols_q       <= '0;
            pos_row_q    <= '0;
            pos_col_q    <= '0;
            cnt_q        <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            cfg_err_q    <= 1'b0;
            pool_err_q   <= 1'b0;
            tile_valid_q <= 1'b0;
            wr_valid_q   <= 1'b0;
            wr_addr_q    <= '0;
            wr_data_q    <= '0;
        end else begin
            state_q      <= state_d;
            rows_q       <= rows_d;
            cols_q       <= cols_d;
            pos_row_q    <= pos_row_d;
            pos_col_q    <= pos_col_d;
            cnt_q        <= cnt_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            cfg_err_q    <= cfg_err_d;
            pool_err_q   <= pool_err_d;
            tile_valid_q <= tile_valid_d;
            wr_valid_q   <= wr_valid_d;
            wr_addr_q    <= wr_addr_d;
            wr_data_q    <= wr_data_d;
        end
    end

    assign busy           = busy_q;
    assign done           = done_q;
    assign cfg_err        = cfg_err_q;
    assign pool_err       = pool_err_q;
    assign bus.tile_valid = tile_valid_q;
    assign bus.pos_row    = pos_row_q;
    assign bus.pos_col    = pos_col_q;
    assign bus.wr_valid   = wr_valid_q;
    assign bus.wr_addr    = wr_addr_q;
    assign bus.wr_data    = wr_data_q;

endmodule
